// File: rtl/l2_port_scheduler_pkg.sv
// Shared types for the L2 port scheduler: FSM states, grant encoding,
// line width and the saturating increment used by the performance counters.
package l2_sched_pkg;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        SERVE_W = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_I    = 2'd1,
        G_D    = 2'd2,
        G_W    = 2'd3
    } grant_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_port_scheduler_if.sv
// Bundle of the three upstream request ports (I-miss, D-miss, write-back
// drain) and the single downstream memory port. The scheduler takes the
// slave view; the L1s, write buffer and memory together form the master view.
interface l2_port_scheduler_if
    import l2_sched_pkg::*;
#(
    parameter int WIDTH = LINE_W
) ();

    // I-cache miss port
    logic             i_read;
    logic [31:0]      i_address;
    logic [WIDTH-1:0] i_rdata;
    logic             i_resp;

    // D-cache miss port
    logic             d_read;
    logic             d_write;
    logic [31:0]      d_address;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_resp;

    // Eviction write-buffer drain port
    logic             wb_write;
    logic             wb_urgent;
    logic [31:0]      wb_address;
    logic [WIDTH-1:0] wb_wdata;
    logic             wb_resp;

    // Downstream L2 / physical memory port
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        input  wb_write, wb_urgent, wb_address, wb_wdata,
        output wb_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        output wb_write, wb_urgent, wb_address, wb_wdata,
        input  wb_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/l2_port_scheduler_prio.sv
// Fixed-order priority select for the scheduler's IDLE decision.
// Urgent drain beats everything; a starved I-side beats D; otherwise D
// beats I, and a non-urgent drain only goes when nobody else wants the port.
module l2_sched_prio
    import l2_sched_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   w_req_i,
    input  logic   w_urgent_i,
    input  logic   streak_max_i,
    output grant_t grant_o
);

    // Walk the priority list top-down and pick the first requester.
    always_comb begin
        grant_o = G_NONE;
        if (w_req_i && w_urgent_i) begin
            grant_o = G_W;
        end else if (i_req_i && streak_max_i) begin
            grant_o = G_I;
        end else if (d_req_i) begin
            grant_o = G_D;
        end else if (i_req_i) begin
            grant_o = G_I;
        end else if (w_req_i) begin
            grant_o = G_W;
        end else begin
            grant_o = G_NONE;
        end
    end

endmodule

// File: rtl/l2_port_scheduler.sv
// Three-way scheduler sharing the single line-wide L2/pmem port between the
// I-miss, D-miss and write-back drain ports. A grant latches the winner's
// address/data/op; the downstream sees only latched values until mem_resp,
// which is forwarded combinationally to the winner and returns us to IDLE.
// Two saturating counters feed the performance unit.
module l2_port_scheduler
    import l2_sched_pkg::*;
#(
    parameter int WIDTH      = LINE_W,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    l2_port_scheduler_if.slave bus,
    output logic [31:0]        conflict_count_o,
    output logic [31:0]        urgent_count_o
);

    localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    sched_state_t        state_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [31:0]         mem_address_q;
    logic [WIDTH-1:0]    mem_wdata_q;
    logic [31:0]         conflict_q;
    logic [31:0]         conflict_d;
    logic [31:0]         urgent_q;
    logic [31:0]         urgent_d;
    logic                streak_max_s;
    logic                d_req_s;
    grant_t              grant_s;

    assign d_req_s      = bus.d_read | bus.d_write;
    assign streak_max_s = (streak_q == STREAK_MAX);

    l2_sched_prio u_prio (
        .i_req_i      (bus.i_read),
        .d_req_i      (d_req_s),
        .w_req_i      (bus.wb_write),
        .w_urgent_i   (bus.wb_urgent),
        .streak_max_i (streak_max_s),
        .grant_o      (grant_s)
    );

    // Streak value to take on a D grant: count only while I is waiting, cap at max.
    always_comb begin
        streak_d = streak_q;
        if (!bus.i_read) begin
            streak_d = {STREAK_W{1'b0}};
        end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_ONE;
        end else begin
            streak_d = streak_q;
        end
    end

    // Scheduler FSM: grant in IDLE, hold latched request until mem_resp.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            streak_q      <= {STREAK_W{1'b0}};
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_wdata_q   <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    case (grant_s)
                        G_I: begin
                            state_q       <= SERVE_I;
                            mem_read_q    <= 1'b1;
                            mem_write_q   <= 1'b0;
                            mem_address_q <= bus.i_address;
                            mem_wdata_q   <= {WIDTH{1'b0}};
                            streak_q      <= {STREAK_W{1'b0}};
                        end
                        G_D: begin
                            state_q       <= SERVE_D;
                            mem_read_q    <= bus.d_read;
                            mem_write_q   <= bus.d_write;
                            mem_address_q <= bus.d_address;
                            mem_wdata_q   <= bus.d_wdata;
                            streak_q      <= streak_d;
                        end
                        G_W: begin
                            state_q       <= SERVE_W;
                            mem_read_q    <= 1'b0;
                            mem_write_q   <= 1'b1;
                            mem_address_q <= bus.wb_address;
                            mem_wdata_q   <= bus.wb_wdata;
                            // An urgent drain may overtake a waiting I; keep its streak.
                            streak_q      <= bus.i_read ? streak_q : {STREAK_W{1'b0}};
                        end
                        default: begin
                            streak_q      <= {STREAK_W{1'b0}};
                        end
                    endcase
                end
                SERVE_I, SERVE_D, SERVE_W: begin
                    if (bus.mem_resp) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Next values of the saturating performance counters.
    always_comb begin
        conflict_d = conflict_q;
        urgent_d   = urgent_q;
        if (bus.i_read && d_req_s) begin
            conflict_d = sat_inc32(conflict_q);
        end else begin
            conflict_d = conflict_q;
        end
        if ((state_q == IDLE) && bus.wb_write && bus.wb_urgent) begin
            urgent_d = sat_inc32(urgent_q);
        end else begin
            urgent_d = urgent_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= 32'd0;
            urgent_q   <= 32'd0;
        end else begin
            conflict_q <= conflict_d;
            urgent_q   <= urgent_d;
        end
    end

    // Drive downstream from latched state; forward mem_resp to the active winner.
    always_comb begin
        bus.mem_read     = mem_read_q;
        bus.mem_write    = mem_write_q;
        bus.mem_address  = mem_address_q;
        bus.mem_wdata    = mem_wdata_q;
        bus.i_rdata      = bus.mem_rdata;
        bus.d_rdata      = bus.mem_rdata;
        bus.i_resp       = (state_q == SERVE_I) & bus.mem_resp;
        bus.d_resp       = (state_q == SERVE_D) & bus.mem_resp;
        bus.wb_resp      = (state_q == SERVE_W) & bus.mem_resp;
        conflict_count_o = conflict_q;
        urgent_count_o   = urgent_q;
    end

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Self-checking bench for l2_port_scheduler: requester/memory models drive
// the interface, a scoreboard holds the expected service order and each
// completion is popped and compared against it.
module tb_l2_port_scheduler;

    localparam int W = 256;

    typedef struct {
        int          port;   // 0 = I, 1 = D, 2 = W
        logic [31:0] addr;
        bit          wr;
        logic [W-1:0] wdata;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] conflict_count;
    logic [31:0] urgent_count;

    l2_port_scheduler_if #(.WIDTH(W)) bus ();

    l2_port_scheduler #(.WIDTH(W), .MAX_STREAK(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .conflict_count_o (conflict_count),
        .urgent_count_o   (urgent_count)
    );

    exp_t sb[$];
    int   n_tests, n_fail;
    int   n_i_resp, n_d_resp, n_w_resp, n_rd_cyc;
    int   i_tgt, i_ack, i_start, d_tgt, d_ack, d_start, w_tgt, w_ack, w_start;
    logic [31:0] i_base, d_base, w_base;
    bit   d_wr, w_urg;
    logic [W-1:0] d_wd, w_wd;
    int   mem_lat, mem_cnt, inject_req, inject_ack;
    logic [31:0] exp_conflict;
    bit   prev_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] mem_pat(input logic [31:0] a);
        return {4{a ^ 32'h1357_9BDF, ~a}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [31:0] addr, input bit wr, input logic [W-1:0] wd);
        exp_t e;
        e.port = port; e.addr = addr; e.wr = wr; e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic issue_i(input int n, input logic [31:0] base);
        i_start = i_ack; i_base = base; i_tgt = i_ack + n;
    endtask

    task automatic issue_d(input int n, input logic [31:0] base, input bit wr, input logic [W-1:0] wd);
        d_start = d_ack; d_base = base; d_wr = wr; d_wd = wd; d_tgt = d_ack + n;
    endtask

    task automatic issue_w(input int n, input logic [31:0] base, input bit urg, input logic [W-1:0] wd);
        w_start = w_ack; w_base = base; w_urg = urg; w_wd = wd; w_tgt = w_ack + n;
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while ((sb.size() != 0 || i_ack < i_tgt || d_ack < d_tgt || w_ack < w_tgt) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", (sb.size() != 0) || (i_ack < i_tgt) || (d_ack < d_tgt) || (w_ack < w_tgt), 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Requester and memory models: sample at the edge, drive 1 time unit later.
    initial begin
        bus.i_read = 1'b0; bus.i_address = 32'd0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = 32'd0; bus.d_wdata = '0;
        bus.wb_write = 1'b0; bus.wb_urgent = 1'b0; bus.wb_address = 32'd0; bus.wb_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        mem_cnt = 0; inject_ack = 0; exp_conflict = 32'd0;
        i_ack = 0; d_ack = 0; w_ack = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_conflict = 32'd0;
            end else if (bus.i_read && (bus.d_read || bus.d_write) && exp_conflict != 32'hFFFF_FFFF) begin
                exp_conflict = exp_conflict + 32'd1;
            end
            #1;
            if (!reset && (bus.mem_read || bus.mem_write)) begin
                mem_cnt++;
                bus.mem_resp = (mem_cnt == mem_lat);
            end else begin
                mem_cnt = 0;
                bus.mem_resp = 1'b0;
            end
            if (inject_req != inject_ack) begin
                inject_ack = inject_req;
                bus.mem_resp = 1'b1;
            end
            bus.mem_rdata = mem_pat(bus.mem_address);
            i_ack = n_i_resp; d_ack = n_d_resp; w_ack = n_w_resp;
            bus.i_read     = (i_ack < i_tgt);
            bus.i_address  = i_base + 32'(64 * (i_ack - i_start));
            bus.d_read     = (d_ack < d_tgt) && !d_wr;
            bus.d_write    = (d_ack < d_tgt) && d_wr;
            bus.d_address  = d_base + 32'(64 * (d_ack - d_start));
            bus.d_wdata    = d_wd;
            bus.wb_write   = (w_ack < w_tgt);
            bus.wb_urgent  = (w_ack < w_tgt) && w_urg;
            bus.wb_address = w_base + 32'(64 * (w_ack - w_start));
            bus.wb_wdata   = w_wd;
        end
    end

    // Completion monitor: pop the scoreboard on every response.
    initial begin
        exp_t e;
        int port;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            chk("d_excl", bus.d_read & bus.d_write, 1'b0);
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("gap", bus.mem_read | bus.mem_write, 1'b0);
                prev_done = bus.mem_resp && (bus.mem_read || bus.mem_write);
                if (bus.mem_read) n_rd_cyc++;
                if (bus.i_resp || bus.d_resp || bus.wb_resp) begin
                    port = bus.i_resp ? 0 : (bus.d_resp ? 1 : 2);
                    chk("resp_qual", bus.mem_resp, 1'b1);
                    chk("one_resp", int'(bus.i_resp) + int'(bus.d_resp) + int'(bus.wb_resp), 1);
                    chk("sb_has_entry", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("port", port, e.port);
                        chk("addr", bus.mem_address, e.addr);
                        chk("op_write", bus.mem_write, e.wr);
                        chk("op_read", bus.mem_read, !e.wr);
                        if (e.wr) chk("wdata", bus.mem_wdata, e.wdata);
                        else if (port == 0) chk("i_rdata", bus.i_rdata, mem_pat(e.addr));
                        else chk("d_rdata", bus.d_rdata, mem_pat(e.addr));
                    end
                    n_i_resp += int'(bus.i_resp);
                    n_d_resp += int'(bus.d_resp);
                    n_w_resp += int'(bus.wb_resp);
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        int rd0, ir0, tot0;
        logic [W-1:0] a5, w1, w2;
        a5 = {32{8'hA5}};
        w1 = {8{32'hDEAD_0001}};
        w2 = {8{32'hBEEF_0002}};
        n_tests = 0; n_fail = 0;
        n_i_resp = 0; n_d_resp = 0; n_w_resp = 0; n_rd_cyc = 0;
        i_tgt = 0; d_tgt = 0; w_tgt = 0; i_start = 0; d_start = 0; w_start = 0;
        i_base = 32'd0; d_base = 32'd0; w_base = 32'd0;
        d_wr = 1'b0; w_urg = 1'b0; d_wd = '0; w_wd = '0;
        inject_req = 0; mem_lat = 2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_resps", {bus.i_resp, bus.d_resp, bus.wb_resp}, 3'b000);
        chk("rst_conflict", conflict_count, 32'd0);
        chk("rst_urgent", urgent_count, 32'd0);
        chk("rst_streak", dut.streak_q, 3'd0);
        reset = 1'b0;

        // I alone, 3-cycle memory latency
        mem_lat = 3; rd0 = n_rd_cyc; ir0 = n_i_resp;
        push(0, 32'h40, 1'b0, '0);
        issue_i(1, 32'h40);
        @(negedge clk);
        chk("t1_not_yet", bus.mem_read, 1'b0);
        @(negedge clk);
        chk("t1_mem_read", bus.mem_read, 1'b1);
        chk("t1_mem_addr", bus.mem_address, 32'h40);
        drain(50);
        chk("t1_read_cycles", n_rd_cyc - rd0, 3);
        chk("t1_i_resp_count", n_i_resp - ir0, 1);
        chk("t1_idle", bus.mem_read, 1'b0);

        // I and D held: D x4, I, D x4, I
        mem_lat = 2;
        for (int k = 0; k < 4; k++) push(1, 32'h2000 + 32'(64 * k), 1'b0, '0);
        push(0, 32'h1000, 1'b0, '0);
        for (int k = 4; k < 8; k++) push(1, 32'h2000 + 32'(64 * k), 1'b0, '0);
        push(0, 32'h1040, 1'b0, '0);
        issue_i(2, 32'h1000);
        issue_d(8, 32'h2000, 1'b0, '0);
        drain(400);
        chk("t2_conflict", conflict_count, exp_conflict);

        // W + D, not urgent: D first
        push(1, 32'h3000, 1'b0, '0);
        push(2, 32'h4000, 1'b1, w1);
        issue_d(1, 32'h3000, 1'b0, '0);
        issue_w(1, 32'h4000, 1'b0, w1);
        drain(100);
        chk("t3_urgent_0", urgent_count, 32'd0);

        // W + D, urgent: W first
        push(2, 32'h4040, 1'b1, w2);
        push(1, 32'h3040, 1'b0, '0);
        issue_w(1, 32'h4040, 1'b1, w2);
        issue_d(1, 32'h3040, 1'b0, '0);
        drain(100);
        chk("t3_urgent_1", urgent_count, 32'd1);
        chk("t3_conflict", conflict_count, exp_conflict);

        // D write; requester changes address/data mid-transaction
        mem_lat = 6;
        push(1, 32'h100, 1'b1, a5);
        issue_d(1, 32'h100, 1'b1, a5);
        repeat (2) @(negedge clk);
        chk("t4_mem_write", bus.mem_write, 1'b1);
        chk("t4_addr_start", bus.mem_address, 32'h100);
        d_base = 32'h200;
        d_wd = {32{8'h5A}};
        repeat (2) @(negedge clk);
        chk("t4_addr_held", bus.mem_address, 32'h100);
        chk("t4_wdata_held", bus.mem_wdata, a5);
        drain(100);

        // Reset two cycles into an I transaction
        mem_lat = 10; ir0 = n_i_resp;
        push(0, 32'h80, 1'b0, '0);
        issue_i(1, 32'h80);
        repeat (2) @(negedge clk);
        chk("t5_started", bus.mem_read, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_mem_read", bus.mem_read, 1'b0);
        chk("t5_mem_write", bus.mem_write, 1'b0);
        chk("t5_mem_address", bus.mem_address, 32'd0);
        chk("t5_mem_wdata", bus.mem_wdata, '0);
        chk("t5_i_resp", bus.i_resp, 1'b0);
        chk("t5_streak", dut.streak_q, 3'd0);
        chk("t5_conflict", conflict_count, 32'd0);
        chk("t5_urgent", urgent_count, 32'd0);
        reset = 1'b0;
        drain(100);
        chk("t5_i_resp_count", n_i_resp - ir0, 1);

        // Stray mem_resp while idle is dropped
        tot0 = n_i_resp + n_d_resp + n_w_resp;
        inject_req = inject_req + 1;
        repeat (3) @(negedge clk);
        chk("t6_no_resp", n_i_resp + n_d_resp + n_w_resp, tot0);
        chk("t6_idle", bus.mem_read | bus.mem_write, 1'b0);

        // Conflict counter saturation
        mem_lat = 2;
        for (int k = 0; k < 3; k++) push(1, 32'h5000 + 32'(64 * k), 1'b0, '0);
        for (int k = 0; k < 3; k++) push(0, 32'h6000 + 32'(64 * k), 1'b0, '0);
        issue_i(3, 32'h6000);
        issue_d(3, 32'h5000, 1'b0, '0);
        repeat (2) @(negedge clk);
        force dut.conflict_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.conflict_q;
        repeat (4) @(negedge clk);
        chk("t7_saturated", conflict_count, 32'hFFFF_FFFF);
        drain(200);
        chk("t7_still_sat", conflict_count, 32'hFFFF_FFFF);
        chk("sb_leftover", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
